alu_console: RTL and testbench

Parametrised board-level ALU exerciser for bring-up on the FPGA board. It replaces pure combinational switch-to-ALU wiring with registered operands A and B, loaded from switches on debounced key presses, plus an execute step that registers the result and flags. A selectable view (A, B or result) is paged across a configurable number of seven-segment digits. It sits above `alu` through `alu_if` and is the top level for ALU board tests.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/fpga_pkg.sv | 37 +++
 rtl/alu_if.sv | 15 +
 rtl/alu.sv | 44 ++++
 rtl/key_debounce.sv | 51 +++++
 rtl/alu_console.sv | 137 +++++++++++++
 tb/tb_alu_console.sv | 208 ++++++++++++++++++++
 7 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: CPU-wide shared types. aluop_t is the ALU operation code.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_AND   = 4'h2,
        ALU_OR    = 4'h3,
        ALU_XOR   = 4'h4,
        ALU_SLL   = 4'h5,
        ALU_SRL   = 4'h6,
        ALU_SRA   = 4'h7,
        ALU_SLT   = 4'h8,
        ALU_SLTU  = 4'h9,
        ALU_NOR   = 4'hA,
        ALU_PASSB = 4'hB
    } aluop_t;

endpackage

// File: rtl/fpga_pkg.sv
// fpga_pkg: board-level types and constants shared by the ALU console.
package fpga_pkg;

    // Which register is shown on the seven-segment display.
    typedef enum logic [1:0] {
        VIEW_A   = 2'b00,
        VIEW_B   = 2'b01,
        VIEW_RES = 2'b10
    } view_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } console_state_t;

    // Ordered so the packed value drops straight onto LEDR[2:0].
    typedef struct packed {
        logic n;
        logic v;
        logic z;
    } alu_flags_t;

    // Active-low segment patterns for hex digits 0..F (constant ROM, no state).
    localparam logic [6:0] SEG7_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
    };

    // Operand load: low-half load sign-extends, high-half load keeps the low half.
    function automatic logic [31:0] load_value(input logic [31:0] cur, input logic [16:0] sw);
        if (sw[16])
            return {sw[15:0], cur[15:0]};
        else
            return {{16{sw[15]}}, sw[15:0]};
    endfunction

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/result bundle between the console and the ALU.
interface alu_if;
    import cpu_types_pkg::*;

    logic [31:0] port_a;
    logic [31:0] port_b;
    aluop_t      aluop;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        negative;

    modport alu  (input port_a, port_b, aluop, output result, zero, overflow, negative);
    modport ctrl (output port_a, port_b, aluop, input result, zero, overflow, negative);
endinterface

// File: rtl/alu.sv
// alu: 32-bit combinational ALU with zero/overflow/negative flags.
module alu
    import cpu_types_pkg::*;
(
    alu_if.alu bus
);

    logic [31:0] res;
    logic        ovf;

    // Result and signed overflow for the selected operation.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        res = '0;
        ovf = 1'b0;
        case (bus.aluop)
            ALU_ADD: begin
                res = bus.port_a + bus.port_b;
                ovf = (bus.port_a[31] == bus.port_b[31]) && (res[31] != bus.port_a[31]);
            end
            ALU_SUB: begin
                res = bus.port_a - bus.port_b;
                ovf = (bus.port_a[31] != bus.port_b[31]) && (res[31] != bus.port_a[31]);
            end
            ALU_AND:   res = bus.port_a & bus.port_b;
            ALU_OR:    res = bus.port_a | bus.port_b;
            ALU_XOR:   res = bus.port_a ^ bus.port_b;
            ALU_SLL:   res = bus.port_a << bus.port_b[4:0];
            ALU_SRL:   res = bus.port_a >> bus.port_b[4:0];
            ALU_SRA:   res = $signed(bus.port_a) >>> bus.port_b[4:0];
            ALU_SLT:   res = {31'b0, $signed(bus.port_a) < $signed(bus.port_b)};
            ALU_SLTU:  res = {31'b0, bus.port_a < bus.port_b};
            ALU_NOR:   res = ~(bus.port_a | bus.port_b);
            ALU_PASSB: res = bus.port_b;
            default:   res = '0;
        endcase
    end

    assign bus.result   = res;
    assign bus.overflow = ovf;
    assign bus.zero     = (res == '0);
    assign bus.negative = res[31];

endmodule

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer, stable-sample counter and press pulse
// for one active-low push button. Resets to the released level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          stable_q;
    logic [CW-1:0] cnt_q;
    logic          accept;

    // Level change accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign accept = (sync_q[1] != stable_q) && (cnt_q == LAST);

    // Two-stage synchronizer into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep register-to-register ordering race-free.
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], key};
    end

    // Count consecutive samples that differ from the accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else if (sync_q[1] == stable_q) begin
            cnt_q    <= '0;
        end else if (accept) begin
            stable_q <= sync_q[1];
            cnt_q    <= '0;
        end else begin
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    // One-cycle pulse on an accepted released-to-pressed transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) press <= 1'b0;
        else     press <= accept && stable_q;
    end

endmodule

// File: rtl/alu_console.sv
// alu_console: board ALU exerciser. Keys load A/B from switches, execute the
// ALU into R and flags, and page the selected view over NDIGITS hex digits.
// Optional macro ALU_CONSOLE_CHAIN_EN: on execute, R is also copied into A.
module alu_console
    import fpga_pkg::*;
    import cpu_types_pkg::*;
#(
    parameter int NDIGITS         = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [3:0]           KEY,
    input  logic [17:0]          SW,
    output logic [7*NDIGITS-1:0] HEX,
    output logic [4:0]           LEDR
);

`ifdef ALU_CONSOLE_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    logic [3:0]     key_pulse;
    console_state_t state_q, state_d;
    logic           do_load_a, do_load_b, do_exec, do_page, do_latch;
    logic [31:0]    a_q, b_q, r_q;
    aluop_t         op_q;
    alu_flags_t     flags_q;
    view_t          view_q;
    logic           page_q;
    logic [31:0]    view_val, shown;
    logic           unused_ok;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (CLK),
            .rst   (RST),
            .key   (KEY[k]),
            .press (key_pulse[k])
        );
    end

    alu_if alu_bus ();
    alu u_alu (.bus(alu_bus));

    assign alu_bus.port_a = a_q;
    assign alu_bus.port_b = b_q;
    assign alu_bus.aluop  = op_q;

    // Next state and one-hot actions; priority KEY0 > KEY1 > KEY2 > KEY3, EXEC ignores keys.
    always_comb begin
        state_d   = state_q;
        do_load_a = 1'b0;
        do_load_b = 1'b0;
        do_exec   = 1'b0;
        do_page   = 1'b0;
        do_latch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_pulse[0])      do_load_a = 1'b1;
                else if (key_pulse[1]) do_load_b = 1'b1;
                else if (key_pulse[2]) begin
                    do_exec = 1'b1;
                    state_d = EXEC;
                end
                else if (key_pulse[3]) do_page = 1'b1;
            end
            EXEC: begin
                do_latch = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Console state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand, opcode, result, flag and display-selection registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            op_q    <= ALU_ADD;
            flags_q <= '0;
            view_q  <= VIEW_RES;
            page_q  <= 1'b0;
        end else begin
            if (do_load_a) begin
                a_q    <= load_value(a_q, SW[16:0]);
                view_q <= VIEW_A;
                page_q <= 1'b0;
            end
            if (do_load_b) begin
                b_q    <= load_value(b_q, SW[16:0]);
                view_q <= VIEW_B;
                page_q <= 1'b0;
            end
            if (do_exec)
                op_q <= aluop_t'(SW[3:0]);
            if (do_latch) begin
                r_q     <= alu_bus.result;
                flags_q <= '{n: alu_bus.negative, v: alu_bus.overflow, z: alu_bus.zero};
                view_q  <= VIEW_RES;
                page_q  <= 1'b0;
                if (CHAIN_EN)
                    a_q <= alu_bus.result;
            end
            if (do_page && NDIGITS == 4)
                page_q <= ~page_q;
        end
    end

    // Select the viewed register and the 16-bit page shown on a 4-digit board.
    always_comb begin
        case (view_q)
            VIEW_A:  view_val = a_q;
            VIEW_B:  view_val = b_q;
            default: view_val = r_q;
        endcase
        shown = page_q ? {16'b0, view_val[31:16]} : view_val;
    end

    for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
        assign HEX[7*i +: 7] = SEG7_HEX[shown[4*i +: 4]];
    end

    assign LEDR      = {view_q, flags_q};
    assign unused_ok = ^{SW[17], shown};

endmodule

// File: tb/tb_alu_console.sv
// tb_alu_console: directed self-checking bench for alu_console (NDIGITS=4,
// DEBOUNCE_CYCLES=4). Expected display values are hand-computed constants.
module tb_alu_console;
    import fpga_pkg::*;

    localparam int DEB = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  key;
    logic [17:0] sw;
    logic [27:0] hex;
    logic [4:0]  ledr;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
    };

    alu_console #(.NDIGITS(4), .DEBOUNCE_CYCLES(DEB)) dut (
        .CLK  (clk),
        .RST  (rst),
        .KEY  (key),
        .SW   (sw),
        .HEX  (hex),
        .LEDR (ledr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_hex(input logic [15:0] v);
        logic [27:0] h;
        for (int i = 0; i < 4; i++) h[7*i +: 7] = SEG[v[4*i +: 4]];
        return {4'b0, h};
    endfunction

    task automatic settle();
        repeat (DEB + 8) @(negedge clk);
    endtask

    task automatic wait_pulse(input int k);
        int n;
        n = 0;
        while (!dut.key_pulse[k] && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check($sformatf("pulse%0d_timeout", k), 32'd1, 32'd0);
    endtask

    // Press key k, wait for its pulse and the register update, then release.
    task automatic press(input int k);
        key[k] = 1'b0;
        wait_pulse(k);
        @(negedge clk);
        key = 4'hF;
        settle();
    endtask

    task automatic load(input int k, input logic [17:0] s);
        sw = s;
        press(k);
    endtask

    task automatic exec(input logic [17:0] s);
        sw = s;
        key[2] = 1'b0;
        wait_pulse(2);
        repeat (2) @(negedge clk);
        key = 4'hF;
        settle();
    endtask

    initial begin
        rst = 1'b1;
        key = 4'hF;
        sw  = '0;
        repeat (3) @(negedge clk);
        check("reset_hex", {4'b0, hex}, {4'b0, {4{7'h40}}});
        check("reset_ledr", 32'(ledr), 32'b10000);
        rst = 1'b0;
        @(negedge clk);

        // Signed low-half load and page toggle.
        load(0, 18'h08001);
        check("loada_view", 32'(ledr), 32'b00000);
        check("loada_hex_p0", {4'b0, hex}, exp_hex(16'h8001));
        press(3);
        check("page1_hex", {4'b0, hex}, exp_hex(16'hFFFF));
        press(3);
        check("page0_hex", {4'b0, hex}, exp_hex(16'h8001));

        // Add 5 + 3 with cycle-level timing.
        load(0, 18'h00005);
        load(1, 18'h00003);
        check("loadb_hex", {4'b0, hex}, exp_hex(16'h0003));
        check("loadb_ledr", 32'(ledr), 32'b01000);
        sw = 18'h00000;
        key[2] = 1'b0;
        wait_pulse(2);
        @(negedge clk);
        check("exec_state", 32'(dut.state_q), 32'd1);
        check("exec_view_pending", 32'(ledr[4:3]), 32'b01);
        @(negedge clk);
        check("add_hex", {4'b0, hex}, exp_hex(16'h0008));
        check("add_ledr", 32'(ledr), 32'b10000);
        check("add_idle", 32'(dut.state_q), 32'd0);
        key = 4'hF;
        settle();

        // Overflow: 0x7FFFFFFF + 1.
        load(0, 18'h0FFFF);
        load(0, 18'h17FFF);
        check("hiload_p0", {4'b0, hex}, exp_hex(16'hFFFF));
        press(3);
        check("hiload_p1", {4'b0, hex}, exp_hex(16'h7FFF));
        load(1, 18'h00001);
        exec(18'h00000);
        check("ovf_hex_p0", {4'b0, hex}, exp_hex(16'h0000));
        check("ovf_ledr", 32'(ledr), 32'b10110);
        press(3);
        check("ovf_hex_p1", {4'b0, hex}, exp_hex(16'h8000));

        // Zero flag: 3 - 3.
        load(0, 18'h00003);
        load(1, 18'h00003);
        exec(18'h00001);
        check("sub_hex", {4'b0, hex}, exp_hex(16'h0000));
        check("sub_ledr", 32'(ledr), 32'b10001);

        // Glitch shorter than the debounce window.
        sw = 18'h00009;
        key[0] = 1'b0;
        repeat (DEB - 1) @(negedge clk);
        key = 4'hF;
        settle();
        check("glitch_ledr", 32'(ledr), 32'b10001);
        check("glitch_hex", {4'b0, hex}, exp_hex(16'h0000));

        // KEY0 and KEY1 together: only A loads.
        sw = 18'h00042;
        key = 4'b1100;
        wait_pulse(0);
        @(negedge clk);
        check("prio_view", 32'(ledr[4:3]), 32'b00);
        check("prio_hex", {4'b0, hex}, exp_hex(16'h0042));
        key = 4'hF;
        settle();
        exec(18'h00000);
        check("prio_b_kept", {4'b0, hex}, exp_hex(16'h0045));

        // KEY1 pulse landing during EXEC is ignored.
        sw = 18'h00000;
        key[2] = 1'b0;
        @(negedge clk);
        key[1] = 1'b0;
        wait_pulse(2);
        repeat (3) @(negedge clk);
        key = 4'hF;
        settle();
        check("exec_ignore_view", 32'(ledr[4:3]), 32'b10);
        exec(18'h00000);
        check("exec_ignore_b", {4'b0, hex}, exp_hex(16'h0045));

        // Reset asserted during EXEC.
        sw = 18'h00000;
        key[2] = 1'b0;
        wait_pulse(2);
        @(negedge clk);
        check("midexec_state", 32'(dut.state_q), 32'd1);
        rst = 1'b1;
        key = 4'hF;
        #1;
        check("midexec_rst_state", 32'(dut.state_q), 32'd0);
        check("midexec_rst_hex", {4'b0, hex}, {4'b0, {4{7'h40}}});
        @(negedge clk);
        rst = 1'b0;
        settle();
        check("midexec_rst_ledr", 32'(ledr), 32'b10000);

`ifdef ALU_CONSOLE_CHAIN_EN
        // Accumulate: A=1, B=1, three adds.
        load(0, 18'h00001);
        load(1, 18'h00001);
        exec(18'h00000);
        exec(18'h00000);
        exec(18'h00000);
        check("chain_hex", {4'b0, hex}, exp_hex(16'h0004));
        check("chain_a", dut.a_q, 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
